// File: rtl/imem_instr_encoder.sv
// Instruction-memory loader: packs RV32I field descriptors into machine words
// and writes them sequentially while holding the core in reset.
module imem_instr_encoder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_fmt,
  input  logic [6:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [31:0]   in_imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err_illegal,
  output logic          err_ovf
);

  localparam int unsigned CW = AW + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic [31:0]   enc_word;
  logic          fmt_legal;
  logic          accept;
  logic          wr_c;
  logic          at_top;
  logic          load_entry;
  logic          ovf_set;
  logic          illegal_set;
  logic          imm_unused;

  // Immediate bits above the widest (J-type) field never reach the word.
  assign imm_unused = ^in_imm[31:21];

  // Pack descriptor fields and check the format/opcode pairing.
  always_comb begin
    enc_word  = '0;
    fmt_legal = 1'b0;
    case (in_fmt)
      3'd0: begin
        enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
        fmt_legal = (in_op == OP_R);
      end
      3'd1: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
        fmt_legal = (in_op == OP_LOAD) || (in_op == OP_IMM);
      end
      3'd2: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
        fmt_legal = (in_op == OP_STORE);
      end
      3'd3: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_op};
        fmt_legal = (in_op == OP_BRANCH);
      end
      3'd4: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
        fmt_legal = (in_op == OP_JAL);
      end
      default: begin
        enc_word  = '0;
        fmt_legal = 1'b0;
      end
    endcase
  end

  // Handshake and write qualification; in_ready is only ever high in LOAD.
  assign accept      = in_valid & in_ready;
  assign wr_c        = accept & fmt_legal;
  assign at_top      = (cnt == CW'(DEPTH - 1));
  assign ovf_set     = wr_c & at_top & ~in_last;
  assign illegal_set = accept & ~fmt_legal;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the last legal write or an overflow write drains for one cycle.
  always_comb begin
    state_d    = state_q;
    load_entry = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          load_entry = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          if (in_last)      state_d = fmt_legal ? DRAIN : DONE;
          else if (ovf_set) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, write port and word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_hold    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_ovf     <= 1'b0;
      cnt         <= '0;
    end else begin
      in_ready <= (state_d == LOAD);
      busy     <= (state_d == LOAD) || (state_d == DRAIN);
      done     <= (state_d == DONE);
      cpu_hold <= (state_d != DONE);
      mem_we   <= wr_c;
      if (wr_c) begin
        mem_addr  <= cnt[AW-1:0];
        mem_wdata <= enc_word;
        cnt       <= cnt + CW'(1);
      end
      if (illegal_set) err_illegal <= 1'b1;
      if (ovf_set)     err_ovf     <= 1'b1;
      if (load_entry) begin
        cnt         <= '0;
        err_illegal <= 1'b0;
        err_ovf     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_instr_encoder.sv
// Directed bench for imem_instr_encoder: a full-size instance plus a DEPTH=4
// instance for the overflow cases.
module tb_imem_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared descriptor fields
  logic [2:0]  in_fmt;
  logic [6:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  // Main instance
  logic        reset, start, in_valid, in_last;
  logic        in_ready, mem_we, cpu_hold, busy, done, err_illegal, err_ovf;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  // Small instance
  logic        reset_s, start_s, valid_s, last_s;
  logic        in_ready_s, mem_we_s, cpu_hold_s, busy_s, done_s, err_illegal_s, err_ovf_s;
  logic [1:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;

  imem_instr_encoder #(.DEPTH(256), .AW(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_ovf(err_ovf)
  );

  imem_instr_encoder #(.DEPTH(4), .AW(2)) u_small (
    .clk(clk), .reset(reset_s), .start(start_s), .in_valid(valid_s), .in_ready(in_ready_s),
    .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(last_s),
    .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .cpu_hold(cpu_hold_s),
    .busy(busy_s), .done(done_s), .err_illegal(err_illegal_s), .err_ovf(err_ovf_s)
  );

  int total  = 0;
  int passed = 0;

  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  logic [1:0]  sq_addr[$];

  // Write logs, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
    if (mem_we_s) sq_addr.push_back(mem_addr_s);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic set_desc(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Offer one descriptor on the main instance; returns at the negedge after acceptance
  task automatic send(input logic last, input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_main();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Hold valid on the small instance until it reports done; last_idx<0 means never last
  task automatic small_stream(input int last_idx, output int acc);
    acc = 0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    valid_s = 1'b1;
    for (int c = 0; c < 20; c++) begin
      last_s = (acc == last_idx);
      if (in_ready_s) begin
        @(posedge clk);
        acc++;
      end
      @(negedge clk);
      if (done_s) break;
    end
    valid_s = 1'b0;
    last_s  = 1'b0;
  endtask

  initial begin
    int acc, cyc;
    reset = 1'b1; reset_s = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    start_s = 1'b0; valid_s = 1'b0; last_s = 1'b0;
    set_desc(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_errs",     32'({err_illegal, err_ovf}), 32'd0);
    reset = 1'b0; reset_s = 1'b0;
    @(negedge clk);

    // Session 1: addi x1,x0,5 ; sw x1,8(x0) last
    start_main();
    chk("s1_in_ready", 32'(in_ready), 32'd1);
    chk("s1_busy",     32'(busy),     32'd1);
    chk("s1_hold",     32'(cpu_hold), 32'd1);
    set_desc(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    send(1'b0, "addi");
    chk("addi_we",   32'(mem_we),   32'd1);
    chk("addi_addr", 32'(mem_addr), 32'd0);
    chk("addi_data", mem_wdata,     32'h00500093);
    set_desc(3'd2, 7'b0100011, 5'd0, 5'd0, 5'd1, 3'd2, 7'd0, 32'd8);
    send(1'b1, "sw");
    chk("sw_we",       32'(mem_we),   32'd1);
    chk("sw_addr",     32'(mem_addr), 32'd1);
    chk("sw_data",     mem_wdata,     32'h00102423);
    chk("drain_ready", 32'(in_ready), 32'd0);
    chk("drain_done",  32'(done),     32'd0);
    @(negedge clk);
    chk("s1_done",      32'(done),     32'd1);
    chk("s1_hold_rel",  32'(cpu_hold), 32'd0);
    chk("s1_done_we",   32'(mem_we),   32'd0);
    chk("s1_done_busy", 32'(busy),     32'd0);

    // Session 2: beq, jal, add (restart from DONE)
    start_main();
    set_desc(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    send(1'b0, "beq");
    chk("beq_addr", 32'(mem_addr), 32'd0);
    chk("beq_data", mem_wdata,     32'hFE208EE3);
    set_desc(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(1'b0, "jal");
    chk("jal_addr", 32'(mem_addr), 32'd1);
    chk("jal_data", mem_wdata,     32'h001000EF);
    set_desc(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(1'b1, "add");
    chk("add_addr", 32'(mem_addr), 32'd2);
    chk("add_data", mem_wdata,     32'h002081B3);
    @(negedge clk);
    chk("s2_done", 32'(done), 32'd1);

    // Session 3: illegal S/R-opcode mismatch mid-stream
    start_main();
    set_desc(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    send(1'b0, "ill_pre");
    chk("ill_pre_addr", 32'(mem_addr), 32'd0);
    set_desc(3'd2, 7'b0110011, 5'd0, 5'd0, 5'd1, 3'd2, 7'd0, 32'd8);
    send(1'b0, "ill");
    chk("ill_we",    32'(mem_we),      32'd0);
    chk("ill_flag",  32'(err_illegal), 32'd1);
    chk("ill_ready", 32'(in_ready),    32'd1);
    set_desc(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(1'b1, "ill_post");
    chk("ill_post_we",   32'(mem_we),      32'd1);
    chk("ill_post_addr", 32'(mem_addr),    32'd1);
    chk("ill_post_data", mem_wdata,        32'h002081B3);
    chk("ill_sticky",    32'(err_illegal), 32'd1);
    @(negedge clk);

    // Session 4: illegal fmt carrying in_last ends at once
    start_main();
    set_desc(3'd5, 7'b0110011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send(1'b1, "ill_last");
    chk("ill_last_done", 32'(done),        32'd1);
    chk("ill_last_we",   32'(mem_we),      32'd0);
    chk("ill_last_flag", 32'(err_illegal), 32'd1);
    chk("ill_last_hold", 32'(cpu_hold),    32'd0);

    // Small instance: overflow without in_last
    set_desc(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    sq_addr.delete();
    small_stream(-1, acc);
    chk("ovf_accepts", 32'(acc),            32'd4);
    chk("ovf_writes",  32'(sq_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < sq_addr.size()) chk($sformatf("ovf_addr%0d", i), 32'(sq_addr[i]), 32'(i));
    chk("ovf_flag",  32'(err_ovf_s),  32'd1);
    chk("ovf_done",  32'(done_s),     32'd1);
    chk("ovf_ready", 32'(in_ready_s), 32'd0);

    // Small instance: in_last exactly on the top address
    sq_addr.delete();
    small_stream(3, acc);
    chk("top_accepts", 32'(acc),            32'd4);
    chk("top_writes",  32'(sq_addr.size()), 32'd4);
    chk("top_no_ovf",  32'(err_ovf_s),      32'd0);
    chk("top_done",    32'(done_s),         32'd1);

    // Main: back-to-back stream, then reset mid-session
    wq_addr.delete();
    wq_data.delete();
    start_main();
    chk("s5_ill_clr", 32'(err_illegal), 32'd0);
    acc = 0;
    cyc = 0;
    in_valid = 1'b1;
    while (acc < 5 && cyc < 20) begin
      set_desc(3'd1, 7'b0010011, 5'(acc + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(acc + 1));
      if (in_ready) begin
        @(posedge clk);
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_accepts", 32'(acc), 32'd5);
    chk("b2b_cycles",  32'(cyc), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we",    32'(mem_we),   32'd0);
    chk("mid_rst_hold",  32'(cpu_hold), 32'd1);
    chk("mid_rst_done",  32'(done),     32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    chk("b2b_writes", 32'(wq_addr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wq_addr.size()) begin
        chk($sformatf("b2b_addr%0d", i), 32'(wq_addr[i]), 32'(i));
        chk($sformatf("b2b_data%0d", i), wq_data[i],
            (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_instr_encoder.md
Name: imem_instr_encoder

Overview:
- Writer/encoder counterpart of the main control decoder: accepts instruction field descriptors over a valid/ready stream, packs them into 32-bit RV32I machine words, writes them sequentially into instruction memory.
- Holds the single-cycle core in reset (cpu_hold) while loading; releases it on completion.
- Encodes exactly the opcode set the core decodes: R-type, load/addi (I), store (S), branch (B), jal (J).

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words (power of 2, ≥2)
- AW, 8, word-address width, = log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin load session (sampled in IDLE or DONE)
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=J, 5-7 illegal
- in_op  in  7  opcode
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3
- in_funct7  in  7
- in_imm  in  32  immediate, sign-extended byte offset
- in_last  in  1  final descriptor of session
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  AW  word address
- mem_wdata  out  32  encoded instruction
- cpu_hold  out  1  core reset/stall request
- busy  out  1  FSM not in IDLE/DONE
- done  out  1  session complete (level)
- err_illegal  out  1  sticky: illegal fmt or fmt/opcode mismatch seen
- err_ovf  out  1  sticky: memory filled before in_last

Behaviour:
- Reset (async): state=IDLE, all outputs 0 except cpu_hold=1; mem_addr=0; stage register empty.
- FSM IDLE -> LOAD on start; DONE -> LOAD on start. Entering LOAD clears done, err_illegal, err_ovf, write address=0; cpu_hold=1 in IDLE/LOAD/DRAIN.
- LOAD: in_ready=1 unless (stage full and not draining this cycle) or write count reached DEPTH. Single stage register; full throughput of 1 word/cycle.
- Encoding (combinational, registered on accept): R: funct7|rs2|rs1|f3|rd|op. I: imm[11:0]|rs1|f3|rd|op. S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op. B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op. J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. Upper imm bits ignored, no range check.
- Legal pairs: R/0110011, I/0000011 or 0010011, S/0100011, B/1100011, J/1101111. Illegal descriptor: accepted (handshake completes), not written, address not advanced, err_illegal set; in_last on it still ends session.
- Latency: descriptor accepted cycle N -> mem_we=1 with mem_addr/mem_wdata valid cycle N+1 (registered); address increments after each write.
- in_last accepted -> DRAIN (in_ready=0); after final write (or immediately if last was illegal) -> DONE.
- Overflow: write to address DEPTH-1 without in_last -> err_ovf=1, DONE next cycle; further descriptors not accepted. in_last on address DEPTH-1 -> DONE, no err_ovf.
- DONE: done=1, cpu_hold=0 (same cycle as entry), in_ready=0, mem_we=0.
- start while LOAD/DRAIN ignored. reset mid-session: immediate abort, partial memory contents untouched, cpu_hold=1.

Test Plan:
- Reset, start, stream addi x1,x0,5 (fmt1,op 0010011) then sw x1,8(x0) with in_last -> writes 0x00500093 @0, 0x00102423 @1; done=1, cpu_hold=0 next cycle.
- B encode: beq x1,x2,imm=-4 -> 0xFE208EE3; jal x1,imm=2048 -> 0x001000EF; R add x3,x1,x2 -> 0x002081B3.
- fmt=2 with op 0110011 mid-stream -> no write, address unchanged, err_illegal=1, following legal word lands at next address.
- DEPTH=4, stream 6 descriptors no in_last -> 4 writes (addr 0-3), err_ovf=1, in_ready=0 after 4th accept, done=1.
- Continuous in_valid with in_ready toggling via back-to-back accepts -> one write per cycle, no dropped/duplicated word; assert reset mid-stream -> mem_we=0, cpu_hold=1, done=0 immediately.
